// File: rtl/cpu_top.sv
// cpu_top: single-cycle 32-bit MIPS-style core with host-loadable IMEM, DMEM and 32x32 register file.
module cpu_top #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        power,
  input  logic        softReset,
  input  logic        writeI,
  input  logic [31:0] dataI,
  input  logic [31:0] TPC,
  output logic        valid
);
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] regs [32];
  logic [31:0] pc, instr, a, b, simm, addr, npc, wval;
  logic [4:0]  wdst;
  logic        we, dwe, run;
  logic        unused_bits;
  assign instr = imem[pc[7:2]];
  assign a     = regs[instr[25:21]];
  assign b     = regs[instr[20:16]];
  assign simm  = {{16{instr[15]}}, instr[15:0]};
  assign addr  = a + simm;
  assign run   = reset & power & ~writeI & ~softReset;
  assign unused_bits = ^{instr[10:6], TPC[31:8], TPC[1:0], addr[31:8], addr[1:0]};
  always_comb begin
    npc  = pc + 32'd4;
    wdst = instr[20:16];
    wval = addr;
    we   = 1'b0;
    dwe  = 1'b0;
    case (instr[31:26])
      6'b001000: we = 1'b1;
      6'b100011: begin
        we   = 1'b1;
        wval = dmem[addr[7:2]];
      end
      6'b101011: dwe = 1'b1;
      6'b000100: npc = (a == b) ? {16'b0, instr[15:0]} : npc;
      6'b000101: npc = (a != b) ? {16'b0, instr[15:0]} : npc;
      6'b000010: npc = {6'b0, instr[25:0]};
      6'b000000: begin
        wdst = instr[15:11];
        we   = 1'b1;
        case (instr[5:0])
          6'b100000: wval = a + b;
          6'b100010: wval = a - b;
          6'b100100: wval = a & b;
          6'b100101: wval = a | b;
          6'b101010: wval = {31'b0, $signed(a) < $signed(b)};
          default:   we = 1'b0;
        endcase
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      valid <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (writeI || softReset || !power) begin
      valid <= 1'b0;
      if (softReset && !writeI) pc <= '0;
    end else begin
      pc    <= npc;
      valid <= 1'b1;
      if (we && wdst != 5'd0) regs[wdst] <= wval;
    end
  end
  // memories keep their contents across reset, so they sit outside the reset domain
  always_ff @(posedge clk) begin
    if (writeI) imem[TPC[7:2]] <= dataI;
    if (run && dwe) dmem[addr[7:2]] <= b;
  end
endmodule

// File: tb/tb_cpu_top.sv
// tb_cpu_top: directed and randomized checks of cpu_top against an instruction-level reference model.
module tb_cpu_top;
  logic        clk = 1'b0, reset = 1'b0, power = 1'b0, softReset = 1'b0, writeI = 1'b0;
  logic [31:0] dataI = '0, TPC = '0;
  logic        valid;
  int checks = 0, errors = 0;
  logic [31:0] m_imem [64];
  logic [31:0] m_dmem [64];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic        m_valid;
  localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010;
  localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_F = 6'b100100, OR_F = 6'b100101, SLT = 6'b101010;

  cpu_top dut (
    .clk(clk), .reset(reset), .power(power), .softReset(softReset),
    .writeI(writeI), .dataI(dataI), .TPC(TPC), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] er(input logic [4:0] rs, rt, rd, input logic [5:0] f);
    return {6'b0, rs, rt, rd, 5'b0, f};
  endfunction
  function automatic logic [31:0] ej(input logic [25:0] t);
    return {JMP, t};
  endfunction

  function automatic logic [31:0] rnd();
    int k;
    logic [4:0] rs, rt, rd;
    logic [15:0] im;
    logic [5:0] f;
    k  = int'($urandom_range(0, 11));
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    case ($urandom_range(0, 5))
      0: f = ADD;
      1: f = SUB;
      2: f = AND_F;
      3: f = OR_F;
      4: f = SLT;
      default: f = 6'($urandom);
    endcase
    case (k)
      0, 1: return {ADDI, rs, rt, im};
      2: return {LW, rs, rt, im};
      3: return {SW, rs, rt, im};
      4: return {BEQ, rs, rt, im & 16'h01FC};
      5: return {BNE, rs, rt, im & 16'h01FC};
      6: return {JMP, 26'($urandom)};
      7, 8, 9, 10: return {6'b0, rs, rt, rd, 5'($urandom), f};
      default: return $urandom;
    endcase
  endfunction

  task automatic wr(input logic [4:0] i, input logic [31:0] v);
    if (i != 5'd0) m_regs[i] = v;
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_valid = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  // one clock edge of the architecture as seen by the programmer
  task automatic model(input logic w, sr, pw, input logic [31:0] d, t);
    logic [31:0] ins, ra, rb, s, ea;
    if (w) begin
      m_imem[t[7:2]] = d;
      m_valid = 1'b0;
    end else if (sr) begin
      m_pc = '0;
      m_valid = 1'b0;
    end else if (!pw) begin
      m_valid = 1'b0;
    end else begin
      ins = m_imem[m_pc[7:2]];
      ra = m_regs[ins[25:21]];
      rb = m_regs[ins[20:16]];
      s  = 32'($signed(ins[15:0]));
      ea = ra + s;
      m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      case (ins[31:26])
        ADDI: wr(ins[20:16], ra + s);
        LW:   wr(ins[20:16], m_dmem[ea[7:2]]);
        SW:   m_dmem[ea[7:2]] = rb;
        BEQ:  if (ra == rb) m_pc = {16'h0, ins[15:0]};
        BNE:  if (ra != rb) m_pc = {16'h0, ins[15:0]};
        JMP:  m_pc = {6'h0, ins[25:0]};
        6'b0: case (ins[5:0])
          ADD:   wr(ins[15:11], ra + rb);
          SUB:   wr(ins[15:11], ra - rb);
          AND_F: wr(ins[15:11], ra & rb);
          OR_F:  wr(ins[15:11], ra | rb);
          SLT:   wr(ins[15:11], ($signed(ra) < $signed(rb)) ? 32'd1 : 32'd0);
          default: ;
        endcase
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_core();
    chk("pc", {24'h0, dut.pc[7:0]}, {24'h0, m_pc[7:0]});
    chk("valid", {31'b0, valid}, {31'b0, m_valid});
    for (int i = 0; i < 32; i++) chk($sformatf("r%0d", i), dut.regs[i], m_regs[i]);
  endtask

  task automatic check_dmem();
    for (int i = 0; i < 64; i++) chk($sformatf("dmem%0d", i), dut.dmem[i], m_dmem[i]);
  endtask

  task automatic step(input logic w, sr, pw, input logic [31:0] d, t);
    writeI = w;
    softReset = sr;
    power = pw;
    dataI = d;
    TPC = t;
    model(w, sr, pw, d, t);
    @(posedge clk);
    @(negedge clk);
    check_core();
  endtask

  task automatic prog(input logic [31:0] a, w);
    step(1'b1, 1'b0, 1'b0, w, a);
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1, '0, '0);
  endtask

  task automatic restart();
    step(1'b0, 1'b1, 1'b0, '0, '0);
  endtask

  // drop reset between edges and look before any clock can act
  task automatic areset();
    #3 reset = 1'b0;
    model_reset();
    #1 check_core();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] p0 [8];
    model_reset();
    for (int i = 0; i < 64; i++) begin
      m_imem[i] = '0;
      m_dmem[i] = '0;
    end
    @(negedge clk);
    check_core();
    reset = 1'b1;

    // program load: a loop that zeroes all of DMEM, then spins at 16
    p0 = '{ei(ADDI, 5'd0, 5'd2, 16'd256), ei(SW, 5'd1, 5'd0, 16'd0), ei(ADDI, 5'd1, 5'd1, 16'd4),
           ei(BNE, 5'd1, 5'd2, 16'd4), ej(26'd16), 32'h0, 32'h0, 32'h0};
    for (int k = 0; k < 8; k++) prog(32'(k << 2), p0[k]);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0);
    chk("load_pc", dut.pc, 32'd0);
    chk("load_valid", {31'b0, valid}, 32'd0);
    for (int k = 0; k < 8; k++) chk($sformatf("imem%0d", k), dut.imem[k], p0[k]);
    restart();
    run(200);
    chk("clear_r1", dut.regs[1], 32'd256);
    chk("clear_pc", dut.pc, 32'd16);
    check_dmem();

    // run sequence
    prog(0, ei(ADDI, 5'd0, 5'd1, 16'd20));
    prog(4, ei(ADDI, 5'd0, 5'd2, 16'd15));
    prog(8, ei(SW, 5'd1, 5'd2, 16'd0));
    prog(12, ei(LW, 5'd1, 5'd1, 16'd0));
    prog(16, er(5'd1, 5'd1, 5'd5, ADD));
    prog(20, ej(26'd0));
    restart();
    run(6);
    chk("seq_dmem5", dut.dmem[5], 32'd15);
    chk("seq_r1", dut.regs[1], 32'd15);
    chk("seq_r5", dut.regs[5], 32'd30);
    chk("seq_pc", dut.pc, 32'd0);
    chk("seq_valid", {31'b0, valid}, 32'd1);

    // branches with absolute targets
    prog(0, ei(BEQ, 5'd3, 5'd0, 16'd128));
    prog(128, ei(ADDI, 5'd0, 5'd4, 16'd1));
    prog(132, ei(BNE, 5'd4, 5'd0, 16'd76));
    prog(76, ei(ADDI, 5'd0, 5'd4, 16'd0));
    prog(80, ei(BNE, 5'd4, 5'd0, 16'd76));
    prog(84, ej(26'd84));
    restart();
    run(1);
    chk("beq_taken", dut.pc, 32'd128);
    run(2);
    chk("bne_taken", dut.pc, 32'd76);
    run(2);
    chk("bne_fall", dut.pc, 32'd84);

    // slt and r0
    prog(0, ei(ADDI, 5'd0, 5'd6, 16'hFFFF));
    prog(4, ei(ADDI, 5'd0, 5'd7, 16'd10));
    prog(8, er(5'd6, 5'd7, 5'd8, SLT));
    prog(12, ei(ADDI, 5'd0, 5'd9, 16'd12));
    prog(16, er(5'd9, 5'd7, 5'd10, SLT));
    prog(20, ei(ADDI, 5'd0, 5'd0, 16'd5));
    prog(24, ej(26'd24));
    restart();
    run(7);
    chk("slt_neg", dut.regs[8], 32'd1);
    chk("slt_pos", dut.regs[10], 32'd0);
    chk("r0_zero", dut.regs[0], 32'd0);

    // control priority
    restart();
    run(2);
    step(1'b1, 1'b0, 1'b1, ej(26'd28), 32'd28);
    chk("wr_valid", {31'b0, valid}, 32'd0);
    chk("wr_pc", dut.pc, 32'd8);
    step(1'b0, 1'b1, 1'b1, '0, '0);
    chk("srst_pc", dut.pc, 32'd0);
    run(3);
    areset();
    chk("arst_pc", dut.pc, 32'd0);
    chk("arst_r7", dut.regs[7], 32'd0);
    run(7);
    chk("rerun_r8", dut.regs[8], 32'd1);

    // arithmetic and PC wrap
    prog(0, ej(26'd248));
    prog(248, ei(ADDI, 5'd0, 5'd1, 16'hFFFF));
    prog(252, er(5'd1, 5'd1, 5'd2, ADD));
    restart();
    run(3);
    chk("wrap_r2", dut.regs[2], 32'hFFFF_FFFE);
    chk("wrap_pc", {24'h0, dut.pc[7:0]}, 32'd0);
    run(1);
    chk("wrap_j", dut.pc, 32'd248);

    // random programs with random control interference
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 64; k++)
        step(1'b1, 1'b0, 1'($urandom_range(0, 1)), rnd(), ($urandom & 32'hFFFF_FF03) | 32'(k << 2));
      restart();
      for (int c = 0; c < 400; c++) begin
        int x;
        x = int'($urandom_range(0, 99));
        if (x < 3) step(1'b1, 1'b0, 1'b1, rnd(), $urandom);
        else if (x < 6) step(1'b0, 1'b1, 1'b1, '0, '0);
        else if (x < 12) step(1'b0, 1'b0, 1'b0, '0, '0);
        else if (x == 12) areset();
        else run(1);
      end
      check_dmem();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
